// File: rtl/abl_unit.sv
// abl_unit: address-low generation unit.
// Selects a base, adds an offset, and registers the result on the low address
// bus. Also holds the low program counter and a small stack of held data-bus
// bytes, and flags the cycle that follows an indexed page crossing.
module abl_unit #(
  parameter int                WIDTH      = 8,
  parameter int                HOLD_DEPTH = 2,
  parameter logic [WIDTH-1:0]  PCL_RESET  = WIDTH'(8'hFC),
  localparam int               SELW       = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             CI,
  input  logic             cond,
  input  logic [WIDTH-1:0] DB,
  input  logic [WIDTH-1:0] REG,
  input  logic [3:0]       op,
  input  logic             ld_ahl,
  input  logic [SELW-1:0]  ahl_sel,
  input  logic             ld_pc,
  input  logic             inc_pc,
  output logic             CO,
  output logic [WIDTH-1:0] ADL,
  output logic [WIDTH-1:0] ABL,
  output logic [WIDTH-1:0] PCL,
  output logic             pcl_co,
  output logic             co_q,
  output logic             page_fix
);

  // Hold depth expressed one bit wider than the selector, for range checks.
  localparam logic [SELW:0] DEPTH_W = (SELW+1)'(HOLD_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FIX  = 1'b1
  } state_t;

  logic [WIDTH-1:0] ahl_r [HOLD_DEPTH];
  logic [WIDTH-1:0] abl_r;
  logic [WIDTH-1:0] pcl_r;
  logic             co_q_r;
  logic             page_fix_r;
  state_t           state_r;

  logic [SELW-1:0]  sel_eff_s;
  logic [WIDTH-1:0] base_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   pcl_sum_s;
  logic             indexed_s;

  // Unsigned three-operand add; the top bit of the result is the carry out.
  function automatic logic [WIDTH:0] add3(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic             c);
    add3 = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  // Out-of-range hold-stack selectors fall back to the newest entry.
  always_comb begin
    sel_eff_s = {SELW{1'b0}};
    if ({1'b0, ahl_sel} < DEPTH_W) begin
      sel_eff_s = ahl_sel;
    end else begin
      sel_eff_s = {SELW{1'b0}};
    end
  end

  // Base multiplexer; the DB base is only taken when the condition holds.
  always_comb begin
    base_s = {WIDTH{1'b0}};
    case (op[3:2])
      2'b00:   base_s = {WIDTH{1'b0}};
      2'b01:   base_s = pcl_r;
      2'b10:   base_s = ahl_r[sel_eff_s];
      2'b11: begin
        if (cond) begin
          base_s = DB;
        end else begin
          base_s = {WIDTH{1'b0}};
        end
      end
      default: base_s = {WIDTH{1'b0}};
    endcase
  end

  // Adder operand selection by add mode.
  always_comb begin
    sum_s = {(WIDTH+1){1'b0}};
    case (op[1:0])
      2'b00:   sum_s = add3({WIDTH{1'b0}}, REG, CI);
      2'b01:   sum_s = add3(base_s, REG, CI);
      2'b10:   sum_s = add3(base_s, {WIDTH{1'b0}}, CI);
      2'b11:   sum_s = add3(base_s, abl_r, CI);
      default: sum_s = {(WIDTH+1){1'b0}};
    endcase
  end

  assign pcl_sum_s = add3(abl_r, {WIDTH{1'b0}}, inc_pc);
  assign indexed_s = (op[1:0] == 2'b01);

  assign ADL      = sum_s[WIDTH-1:0];
  assign CO       = sum_s[WIDTH];
  assign pcl_co   = pcl_sum_s[WIDTH];
  assign ABL      = abl_r;
  assign PCL      = pcl_r;
  assign co_q     = co_q_r;
  assign page_fix = page_fix_r;

  // Address bus low and its registered carry advance together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abl_r  <= {WIDTH{1'b0}};
      co_q_r <= 1'b0;
    end else if (rdy) begin
      abl_r  <= sum_s[WIDTH-1:0];
      co_q_r <= sum_s[WIDTH];
    end
  end

  // Hold stack: newest DB byte enters at entry 0, the oldest drops off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        ahl_r[i] <= {WIDTH{1'b0}};
      end
    end else if (rdy && ld_ahl) begin
      ahl_r[0] <= DB;
      for (int i = 1; i < HOLD_DEPTH; i++) begin
        ahl_r[i] <= ahl_r[i-1];
      end
    end
  end

  // Program counter low loads from the current (pre-edge) address bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcl_r <= PCL_RESET;
    end else if (rdy && ld_pc) begin
      pcl_r <= pcl_sum_s[WIDTH-1:0];
    end
  end

  // Page-fix FSM: one rdy cycle of FIX after an indexed add carries out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      page_fix_r <= 1'b0;
    end else if (rdy) begin
      case (state_r)
        ST_IDLE: begin
          if (indexed_s && sum_s[WIDTH]) begin
            state_r    <= ST_FIX;
            page_fix_r <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            page_fix_r <= 1'b0;
          end
        end
        ST_FIX: begin
          state_r    <= ST_IDLE;
          page_fix_r <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          page_fix_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_abl_unit.sv
// Directed bench for abl_unit (WIDTH=8, HOLD_DEPTH=2) with hand-computed values.
module tb_abl_unit;

  logic       clk = 1'b0;
  logic       rst_n, rdy, CI, cond, ld_ahl, ahl_sel, ld_pc, inc_pc;
  logic [7:0] DB, REG;
  logic [3:0] op;
  logic       CO, pcl_co, co_q, page_fix;
  logic [7:0] ADL, ABL, PCL;

  int errors = 0;
  int checks = 0;

  abl_unit #(.WIDTH(8), .HOLD_DEPTH(2), .PCL_RESET(8'hFC)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .CI(CI), .cond(cond),
    .DB(DB), .REG(REG), .op(op), .ld_ahl(ld_ahl), .ahl_sel(ahl_sel),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .CO(CO), .ADL(ADL), .ABL(ABL),
    .PCL(PCL), .pcl_co(pcl_co), .co_q(co_q), .page_fix(page_fix)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b1; rdy = 1'b1; CI = 1'b0; cond = 1'b0; ld_ahl = 1'b0;
    ahl_sel = 1'b0; ld_pc = 1'b0; inc_pc = 1'b0; DB = 8'h00; REG = 8'h00;
    op = 4'b0000;

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_abl", ABL, 8'h00);
    check("rst_pcl", PCL, 8'hFC);
    check("rst_ahl0", dut.ahl_r[0], 8'h00);
    check("rst_ahl1", dut.ahl_r[1], 8'h00);
    check("rst_coq", co_q, 1'b0);
    check("rst_pfix", page_fix, 1'b0);
    check("rst_adl", ADL, 8'h00);
    #5 rst_n = 1'b1;

    // Indexed page cross
    ld_ahl = 1'b1; DB = 8'hF0;
    step();
    ld_ahl = 1'b0;
    check("pc_ahl0", dut.ahl_r[0], 8'hF0);
    check("pc_ahl1", dut.ahl_r[1], 8'h00);
    op = 4'b1001; REG = 8'h20; CI = 1'b0;
    settle();
    check("pc_adl", ADL, 8'h10);
    check("pc_co", CO, 1'b1);
    step();
    check("pc_abl", ABL, 8'h10);
    check("pc_coq", co_q, 1'b1);
    check("pc_fix1", page_fix, 1'b1);
    step();  // carry again while in FIX: must still leave FIX
    check("pc_fix_end", page_fix, 1'b0);
    step();  // carry from IDLE re-enters FIX
    check("pc_fix_again", page_fix, 1'b1);
    op = 4'b0000; REG = 8'hFE;
    step();
    check("pc_fix_clear", page_fix, 1'b0);
    check("ld_abl_fe", ABL, 8'hFE);

    // Branch wrap
    cond = 1'b1; op = 4'b1111; DB = 8'h03; CI = 1'b0;
    settle();
    check("br_adl", ADL, 8'h01);
    check("br_co", CO, 1'b1);
    step();
    check("br_abl", ABL, 8'h01);
    check("br_coq", co_q, 1'b1);
    check("br_pfix", page_fix, 1'b0);
    cond = 1'b0; CI = 1'b1;
    settle();
    check("br_nocond_adl", ADL, 8'h02);
    check("br_nocond_co", CO, 1'b0);

    // PC increment wrap
    op = 4'b0000; REG = 8'hFF; CI = 1'b0;
    step();
    check("pcw_abl", ABL, 8'hFF);
    ld_pc = 1'b1; inc_pc = 1'b1;
    settle();
    check("pcw_pclco", pcl_co, 1'b1);
    step();
    check("pcw_pcl00", PCL, 8'h00);
    inc_pc = 1'b0;
    settle();
    check("pcw_pclco0", pcl_co, 1'b0);
    step();
    check("pcw_pclff", PCL, 8'hFF);
    ld_pc = 1'b0;
    op = 4'b0110; CI = 1'b1;
    settle();
    check("pcbase_adl", ADL, 8'h00);
    check("pcbase_co", CO, 1'b1);

    // Hold stack
    op = 4'b0000; REG = 8'h00; CI = 1'b0;
    ld_ahl = 1'b1; DB = 8'h12;
    step();
    DB = 8'h34;
    step();
    ld_ahl = 1'b0;
    check("hs_ahl0", dut.ahl_r[0], 8'h34);
    check("hs_ahl1", dut.ahl_r[1], 8'h12);
    op = 4'b1010; ahl_sel = 1'b1; CI = 1'b1;
    settle();
    check("hs_sel1", ADL, 8'h13);
    ahl_sel = 1'b0;
    settle();
    check("hs_sel0", ADL, 8'h35);

    // Stall with every load active
    rdy = 1'b0; ld_ahl = 1'b1; DB = 8'hAA; ld_pc = 1'b1; inc_pc = 1'b1;
    op = 4'b1001; ahl_sel = 1'b0; REG = 8'hF0; CI = 1'b0;
    settle();
    check("st_co", CO, 1'b1);
    step(); step(); step();
    check("st_abl", ABL, 8'h00);
    check("st_pcl", PCL, 8'hFF);
    check("st_ahl0", dut.ahl_r[0], 8'h34);
    check("st_ahl1", dut.ahl_r[1], 8'h12);
    check("st_coq", co_q, 1'b0);
    check("st_pfix", page_fix, 1'b0);
    rdy = 1'b1;
    step();
    check("rs_abl", ABL, 8'h24);
    check("rs_coq", co_q, 1'b1);
    check("rs_pfix", page_fix, 1'b1);
    check("rs_pcl", PCL, 8'h01);
    check("rs_ahl0", dut.ahl_r[0], 8'hAA);
    check("rs_ahl1", dut.ahl_r[1], 8'h34);

    // Reset while in FIX
    ld_ahl = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mr_pfix", page_fix, 1'b0);
    check("mr_abl", ABL, 8'h00);
    check("mr_pcl", PCL, 8'hFC);
    check("mr_ahl0", dut.ahl_r[0], 8'h00);
    check("mr_coq", co_q, 1'b0);
    check("mr_adl", ADL, 8'hF0);
    check("mr_co", CO, 1'b0);
    #1 rst_n = 1'b1;
    ld_pc = 1'b0; op = 4'b0101; REG = 8'h10;
    settle();
    check("ar_adl", ADL, 8'h0C);
    step();
    check("ar_pfix", page_fix, 1'b1);
    check("ar_abl", ABL, 8'h0C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
